// File: rtl/id_stage.sv
// Instruction-decode pipeline stage.
// Holds one instruction handed over by IF. It decodes the fields, the one-hot
// class and the immediate, and presents them to EX under a valid/allow-in
// handshake. It also stalls the instruction behind a load whose destination
// it reads (load-use hazard).
module id_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_to_id_valid,
    input  logic [63:0]  if_to_id_bus,
    input  logic [31:0]  irom_dout,
    output logic         id_allow_in,
    input  logic         br_taken,
    input  logic         ex_allow_in,
    input  logic         ex_valid,
    input  logic         ex_is_load,
    input  logic [4:0]   ex_rd,
    output logic [4:0]   rf_raddr1,
    output logic [4:0]   rf_raddr2,
    output logic         id_to_ex_valid,
    output logic [124:0] id_to_ex_bus
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // op_class bit positions
    localparam int C_LUI    = 0;
    localparam int C_AUIPC  = 1;
    localparam int C_JAL    = 2;
    localparam int C_JALR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_LOAD   = 5;
    localparam int C_STORE  = 6;
    localparam int C_OPIMM  = 7;
    localparam int C_OP     = 8;

    // Reset leaves a NOP (ADDI x0,x0,0) in the instruction register. The
    // decoded bus is then well defined even while id_valid is low.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_pc4_q,   id_pc4_d;
    logic [31:0] id_inst_q,  id_inst_d;

    logic        id_ready_go;
    logic        load_use_stall;
    logic        accept;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        funct7b5;

    logic [8:0]  op_class;
    logic        illegal;
    logic [31:0] imm;
    logic        uses_rs1;
    logic        uses_rs2;

    // Handshake: ID can take a new instruction when empty or when its current one leaves this cycle
    always_comb begin
        id_ready_go    = !load_use_stall;
        id_allow_in    = !id_valid_q || (id_ready_go && ex_allow_in);
        id_to_ex_valid = id_valid_q && id_ready_go;
        accept         = if_to_id_valid && id_allow_in && !br_taken;
    end

    // Next-state for the stage registers. A redirect drops both the held
    // instruction and anything offered in the same cycle.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_inst_d  = id_inst_q;
        if (br_taken) begin
            id_valid_d = 1'b0;
        end else if (id_allow_in) begin
            id_valid_d = if_to_id_valid;
        end
        if (accept) begin
            id_pc_d   = if_to_id_bus[31:0];
            id_pc4_d  = if_to_id_bus[63:32];
            id_inst_d = irom_dout;
        end
    end

    // Stage registers; reset overrides stall and flush in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_pc4_q   <= 32'h0;
            id_inst_q  <= INST_NOP;
        end else begin
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_inst_q  <= id_inst_d;
        end
    end

    // Field extraction from the held instruction word
    always_comb begin
        opcode   = id_inst_q[6:0];
        rd       = id_inst_q[11:7];
        funct3   = id_inst_q[14:12];
        rs1      = id_inst_q[19:15];
        rs2      = id_inst_q[24:20];
        funct7b5 = id_inst_q[30];
        rf_raddr1 = rs1;
        rf_raddr2 = rs2;
    end

    // One-hot instruction class; unknown opcodes are flagged illegal
    always_comb begin
        op_class = 9'b0;
        illegal  = 1'b0;
        case (opcode)
            OPC_LUI:    op_class[C_LUI]    = 1'b1;
            OPC_AUIPC:  op_class[C_AUIPC]  = 1'b1;
            OPC_JAL:    op_class[C_JAL]    = 1'b1;
            OPC_JALR:   op_class[C_JALR]   = 1'b1;
            OPC_BRANCH: op_class[C_BRANCH] = 1'b1;
            OPC_LOAD:   op_class[C_LOAD]   = 1'b1;
            OPC_STORE:  op_class[C_STORE]  = 1'b1;
            OPC_OPIMM:  op_class[C_OPIMM]  = 1'b1;
            OPC_OP:     op_class[C_OP]     = 1'b1;
            default:    illegal            = 1'b1;
        endcase
    end

    // Sign-extended immediate selected by instruction format
    always_comb begin
        imm = 32'h0;
        if (op_class[C_JALR] || op_class[C_LOAD] || op_class[C_OPIMM]) begin
            imm = {{20{id_inst_q[31]}}, id_inst_q[31:20]};
        end else if (op_class[C_STORE]) begin
            imm = {{20{id_inst_q[31]}}, id_inst_q[31:25], id_inst_q[11:7]};
        end else if (op_class[C_BRANCH]) begin
            imm = {{19{id_inst_q[31]}}, id_inst_q[31], id_inst_q[7],
                   id_inst_q[30:25], id_inst_q[11:8], 1'b0};
        end else if (op_class[C_LUI] || op_class[C_AUIPC]) begin
            imm = {id_inst_q[31:12], 12'h000};
        end else if (op_class[C_JAL]) begin
            imm = {{11{id_inst_q[31]}}, id_inst_q[31], id_inst_q[19:12],
                   id_inst_q[20], id_inst_q[30:21], 1'b0};
        end
    end

    // Load-use hazard: the load result is not forwardable in time, so the
    // consumer waits in ID. x0 is never a real dependency.
    always_comb begin
        uses_rs1 = op_class[C_JALR] | op_class[C_BRANCH] | op_class[C_LOAD] |
                   op_class[C_STORE] | op_class[C_OPIMM] | op_class[C_OP];
        uses_rs2 = op_class[C_BRANCH] | op_class[C_STORE] | op_class[C_OP];
        load_use_stall = id_valid_q && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                         ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    end

    // Decoded bus is a pure function of the held registers, so it stays stable while stalled
    always_comb begin
        id_to_ex_bus = {illegal, op_class, funct7b5, funct3, rs2, rs1, rd,
                        imm, id_pc4_q, id_pc_q};
    end

endmodule
